// File: rtl/string_draw_scheduler.sv
// Round-robin scheduler that shares one string-draw engine between NREQ requesters,
// sequencing each job through line reset, settle, run and a one-cycle finish.
module string_draw_scheduler #(
  parameter int NREQ    = 3,
  parameter int SLEN    = 14,
  parameter int TIMEOUT = 65535
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*SLEN*7-1:0] req_str,
  input  logic [NREQ*11-1:0]     req_x,
  input  logic [NREQ*11-1:0]     req_y,
  input  logic [NREQ-1:0]        req_color,
  output logic [NREQ-1:0]        req_done,
  output logic                   eng_reset,
  output logic                   eng_start,
  input  logic                   eng_done,
  output logic [SLEN*7-1:0]      eng_str,
  output logic [10:0]            eng_x_off,
  output logic [10:0]            eng_y_off,
  output logic                   pixel_color,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW   = SLEN * 7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    SETTLE = 3'd2,
    RUN    = 3'd3,
    FINISH = 3'd4
  } state_t;

  state_t            state_r;
  logic [IDXW-1:0]   last_served_r;
  logic [IDXW-1:0]   grant_r;
  logic [1:0]        phase_cnt_r;
  logic [15:0]       run_cnt_r;
  logic              rst_hold_r;

  logic [IDXW-1:0]   pick_idx_s;
  logic              pick_valid_s;
  logic [2*NREQ-1:0] rot_s;
  int                start_s;
  int                idx_s;

  // Round-robin pick: rotate so bit 0 is the requester after last_served, lowest set bit wins.
  always_comb begin
    pick_valid_s = 1'b0;
    pick_idx_s   = {IDXW{1'b0}};
    idx_s        = 0;
    start_s      = (int'(last_served_r) >= NREQ - 1) ? 0 : int'(last_served_r) + 1;
    rot_s        = {req, req} >> start_s;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot_s[k]) begin
        idx_s        = (start_s + k >= NREQ) ? start_s + k - NREQ : start_s + k;
        pick_valid_s = 1'b1;
        pick_idx_s   = IDXW'(idx_s);
      end else begin
        pick_valid_s = pick_valid_s;
      end
    end
  end

  assign busy = (state_r != IDLE);

  // Job sequencer; every engine-facing output is registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      last_served_r <= IDXW'(NREQ - 1);
      grant_r       <= {IDXW{1'b0}};
      phase_cnt_r   <= 2'd0;
      run_cnt_r     <= 16'd0;
      rst_hold_r    <= 1'b1;
      req_done      <= {NREQ{1'b0}};
      eng_reset     <= 1'b0;
      eng_start     <= 1'b0;
      eng_str       <= {SW{1'b0}};
      eng_x_off     <= 11'd0;
      eng_y_off     <= 11'd0;
      pixel_color   <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      rst_hold_r <= 1'b0;
      req_done   <= {NREQ{1'b0}};
      case (state_r)
        IDLE: begin
          // The cycle right after reset release never grants.
          if (!rst_hold_r && pick_valid_s) begin
            grant_r     <= pick_idx_s;
            eng_str     <= req_str[pick_idx_s*SW +: SW];
            eng_x_off   <= req_x[pick_idx_s*11 +: 11];
            eng_y_off   <= req_y[pick_idx_s*11 +: 11];
            pixel_color <= req_color[pick_idx_s];
            eng_reset   <= 1'b1;
            phase_cnt_r <= 2'd0;
            state_r     <= CLEAR;
          end
        end
        CLEAR: begin
          if (phase_cnt_r == 2'd1) begin
            eng_reset   <= 1'b0;
            phase_cnt_r <= 2'd0;
            state_r     <= SETTLE;
          end else begin
            phase_cnt_r <= phase_cnt_r + 2'd1;
          end
        end
        SETTLE: begin
          if (phase_cnt_r == 2'd3) begin
            eng_start   <= 1'b1;
            phase_cnt_r <= 2'd0;
            run_cnt_r   <= 16'd0;
            state_r     <= RUN;
          end else begin
            phase_cnt_r <= phase_cnt_r + 2'd1;
          end
        end
        RUN: begin
          // A done seen on the last allowed cycle still counts as a completion.
          if (eng_done) begin
            eng_start         <= 1'b0;
            req_done[grant_r] <= 1'b1;
            state_r           <= FINISH;
          end else if ((run_cnt_r + 16'd1) == 16'(TIMEOUT)) begin
            eng_start   <= 1'b0;
            timeout_err <= 1'b1;
            state_r     <= FINISH;
          end else begin
            run_cnt_r <= run_cnt_r + 16'd1;
          end
        end
        FINISH: begin
          last_served_r <= grant_r;
          run_cnt_r     <= 16'd0;
          state_r       <= IDLE;
        end
        default: begin
          eng_reset <= 1'b0;
          eng_start <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_string_draw_scheduler.sv
// Randomized bench for string_draw_scheduler: a job-level reference model predicts the
// winner, phase lengths, outcome and latched data of every job.
module tb_string_draw_scheduler;

  localparam int NREQ    = 3;
  localparam int SLEN    = 14;
  localparam int TIMEOUT = 100;
  localparam int SW      = SLEN * 7;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [NREQ-1:0]        req = '0;
  logic [NREQ*SW-1:0]     req_str = '0;
  logic [NREQ*11-1:0]     req_x = '0;
  logic [NREQ*11-1:0]     req_y = '0;
  logic [NREQ-1:0]        req_color = '0;
  logic                   eng_done = 1'b0;
  logic [NREQ-1:0]        req_done;
  logic                   eng_reset;
  logic                   eng_start;
  logic [SW-1:0]          eng_str;
  logic [10:0]            eng_x_off;
  logic [10:0]            eng_y_off;
  logic                   pixel_color;
  logic                   busy;
  logic                   timeout_err;

  int vectors = 0;
  int miscompares = 0;
  int last_served = NREQ - 1;
  bit terr_model = 1'b0;

  string_draw_scheduler #(.NREQ(NREQ), .SLEN(SLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .req_str(req_str), .req_x(req_x),
    .req_y(req_y), .req_color(req_color), .req_done(req_done),
    .eng_reset(eng_reset), .eng_start(eng_start), .eng_done(eng_done),
    .eng_str(eng_str), .eng_x_off(eng_x_off), .eng_y_off(eng_y_off),
    .pixel_color(pixel_color), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Spec rule: search from last_served+1 upward, wrapping modulo NREQ.
  function automatic int model_pick(input logic [NREQ-1:0] r, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic rand_inputs;
    for (int i = 0; i < NREQ; i++) begin
      for (int c = 0; c < SLEN; c++) req_str[i*SW + c*7 +: 7] = 7'($urandom);
      req_x[i*11 +: 11] = 11'($urandom);
      req_y[i*11 +: 11] = 11'($urandom);
      req_color[i]      = 1'($urandom);
    end
  endtask

  task automatic do_reset;
    req = '0;
    eng_done = 1'b0;
    reset = 1'b1;
    step;
    step;
    reset = 1'b0;
    last_served = NREQ - 1;
    terr_model = 1'b0;
    step;
  endtask

  // delay 0: eng_done held high from before the grant; otherwise done rises after delay RUN cycles.
  task automatic run_job(input int idx, input int delay, input bit churn, input bit drop);
    logic [SW-1:0]   s;
    logic [10:0]     x, y;
    logic            c;
    logic [NREQ-1:0] want_done;
    int              n, exp_n;
    bit              tmo;
    s = req_str[idx*SW +: SW];
    x = req_x[idx*11 +: 11];
    y = req_y[idx*11 +: 11];
    c = req_color[idx];
    tmo = (delay >= TIMEOUT);
    exp_n = (delay == 0) ? 1 : (tmo ? TIMEOUT : delay);
    if (delay == 0) eng_done = 1'b1;
    step;
    vectors++;
    if (eng_reset !== 1'b1 || busy !== 1'b1)
      $display("FAIL grant: eng_reset=%b busy=%b, want 1 1 (req %0d)", eng_reset, busy, idx);
    vectors++;
    if (eng_str !== s || eng_x_off !== x || eng_y_off !== y || pixel_color !== c) begin
      miscompares++;
      $display("FAIL latch: str=%h x=%0d y=%0d col=%b, want %h %0d %0d %b", eng_str, eng_x_off,
               eng_y_off, pixel_color, s, x, y, c);
    end
    if (eng_reset !== 1'b1 || busy !== 1'b1) miscompares++;
    step;
    vectors++;
    if (eng_reset !== 1'b1 || eng_start !== 1'b0) begin
      miscompares++;
      $display("FAIL clear2: eng_reset=%b eng_start=%b, want 1 0", eng_reset, eng_start);
    end
    if (drop) req[idx] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step;
      vectors++;
      if (eng_reset !== 1'b0 || eng_start !== 1'b0 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL settle%0d: eng_reset=%b eng_start=%b busy=%b, want 0 0 1", i, eng_reset,
                 eng_start, busy);
      end
    end
    n = 0;
    for (int t = 0; t < TIMEOUT + 10; t++) begin
      step;
      if (eng_start !== 1'b1) break;
      n++;
      if (delay > 0) eng_done = (n >= delay);
      vectors++;
      if (eng_str !== s || eng_x_off !== x || eng_y_off !== y || pixel_color !== c ||
          req_done !== '0) begin
        miscompares++;
        $display("FAIL hold: str=%h x=%0d col=%b done=%b, want %h %0d %b 000", eng_str,
                 eng_x_off, pixel_color, req_done, s, x, c);
      end
      if (churn) begin
        for (int k = 0; k < SLEN; k++) req_str[k*7 +: 7] = 7'($urandom);
        req_x[10:0] = 11'($urandom);
      end
    end
    if (tmo) terr_model = 1'b1;
    want_done = tmo ? '0 : (NREQ'(1) << idx);
    vectors++;
    if (n != exp_n) begin
      miscompares++;
      $display("FAIL run_len: %0d RUN cycles, want %0d", n, exp_n);
    end
    vectors++;
    if (req_done !== want_done || busy !== 1'b1 || eng_start !== 1'b0) begin
      miscompares++;
      $display("FAIL finish: req_done=%b busy=%b eng_start=%b, want %b 1 0", req_done, busy,
               eng_start, want_done);
    end
    vectors++;
    if (timeout_err !== terr_model) begin
      miscompares++;
      $display("FAIL timeout_err: %b, want %b", timeout_err, terr_model);
    end
    eng_done = 1'b0;
    last_served = idx;
    step;
    vectors++;
    if (busy !== 1'b0 || req_done !== '0 || eng_reset !== 1'b0 || eng_start !== 1'b0 ||
        pixel_color !== c || eng_x_off !== x) begin
      miscompares++;
      $display("FAIL idle: busy=%b done=%b rst=%b start=%b col=%b x=%0d, want 0 000 0 0 %b %0d",
               busy, req_done, eng_reset, eng_start, pixel_color, eng_x_off, c, x);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step;
    step;
    vectors++;
    if ({eng_reset, eng_start, req_done, pixel_color, timeout_err, busy} !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_ctl: rst=%b start=%b done=%b col=%b terr=%b busy=%b, want all 0",
               eng_reset, eng_start, req_done, pixel_color, timeout_err, busy);
    end
    vectors++;
    if (eng_str !== '0 || eng_x_off !== 11'd0 || eng_y_off !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_data: str=%h x=%0d y=%0d, want 0 0 0", eng_str, eng_x_off, eng_y_off);
    end
    reset = 1'b0;
    step;
  endtask

  task automatic test_single;
    string w;
    w = "WELCOME";
    rand_inputs();
    req_str[SW-1:0] = '0;
    for (int i = 0; i < w.len(); i++) req_str[i*7 +: 7] = w[i][6:0];
    req_x[10:0] = 11'd220;
    req_y[10:0] = 11'd10;
    req_color[0] = 1'b1;
    req = 3'b001;
    run_job(model_pick(req, last_served), 0, 1'b0, 1'b0);
    req = '0;
  endtask

  task automatic test_erase;
    rand_inputs();
    req_x[21:11] = 11'd150;
    req_y[21:11] = 11'd60;
    req_color[1] = 1'b0;
    req = 3'b010;
    run_job(model_pick(req, last_served), 3, 1'b0, 1'b0);
    req = '0;
    for (int i = 0; i < 4; i++) begin
      step;
      vectors++;
      if (pixel_color !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL erase_idle: pixel_color=%b busy=%b, want 0 0", pixel_color, busy);
      end
    end
  endtask

  task automatic test_contention;
    do_reset();
    rand_inputs();
    req = 3'b111;
    for (int j = 0; j < 4; j++) run_job(model_pick(req, last_served), 20, 1'b0, 1'b0);
    req = '0;
  endtask

  task automatic test_timeout;
    do_reset();
    rand_inputs();
    req = 3'b001;
    run_job(model_pick(req, last_served), 1000, 1'b0, 1'b0);
    run_job(model_pick(req, last_served), 5, 1'b0, 1'b0);
    req = '0;
  endtask

  task automatic test_mid_reset;
    rand_inputs();
    req_color[2] = 1'b1;
    req = 3'b100;
    step;
    step;
    step;
    reset = 1'b1;
    step;
    vectors++;
    if ({eng_reset, eng_start, req_done, pixel_color, timeout_err, busy} !== 8'd0 ||
        eng_str !== '0 || eng_x_off !== 11'd0 || eng_y_off !== 11'd0) begin
      miscompares++;
      $display("FAIL mid_reset: rst=%b start=%b done=%b col=%b terr=%b busy=%b x=%0d, want 0s",
               eng_reset, eng_start, req_done, pixel_color, timeout_err, busy, eng_x_off);
    end
    reset = 1'b0;
    last_served = NREQ - 1;
    terr_model = 1'b0;
    step;
    vectors++;
    if (eng_reset !== 1'b0 || busy !== 1'b0 || req_done !== '0) begin
      miscompares++;
      $display("FAIL release: eng_reset=%b busy=%b done=%b, want 0 0 000", eng_reset, busy,
               req_done);
    end
    run_job(model_pick(req, last_served), 4, 1'b0, 1'b0);
    req = '0;
  endtask

  task automatic test_churn;
    rand_inputs();
    req = 3'b001;
    run_job(model_pick(req, last_served), 10, 1'b1, 1'b0);
    req = '0;
  endtask

  task automatic test_random;
    for (int j = 0; j < 25; j++) begin
      rand_inputs();
      req = NREQ'($urandom_range(1, 7));
      run_job(model_pick(req, last_served), int'($urandom_range(1, 30)), 1'b0,
              1'($urandom_range(0, 1)));
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_erase();
    test_contention();
    test_timeout();
    test_mid_reset();
    test_churn();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/string_draw_scheduler.md
STRING_DRAW_SCHEDULER -- requirements
Module: string_draw_scheduler

Interface
REQ-001 Parameter NREQ, default 3: number of string-draw requesters.
REQ-002 Parameter SLEN, default 14: characters per string, 7-bit codes each.
REQ-003 Parameter TIMEOUT, default 65535: maximum RUN cycles before abort.
REQ-004 clk  input  1  system clock; all logic rising-edge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 req  input  NREQ  per-requester draw request, level, held until req_done.
REQ-007 req_str  input  NREQ*SLEN*7  per-requester character codes, character 0 in the LSBs.
REQ-008 req_x, req_y  input  NREQ*11 each  per-requester pixel offsets.
REQ-009 req_color  input  NREQ  per-requester pixel colour (1 = draw, 0 = erase).
REQ-010 req_done  output  NREQ  one-cycle pulse when that requester's string completes.
REQ-011 eng_reset  output  1  line-reset to the string engine.
REQ-012 eng_start  output  1  start to the string engine.
REQ-013 eng_done  input  1  string engine done.
REQ-014 eng_str  output  SLEN*7  latched string to the engine.
REQ-015 eng_x_off, eng_y_off  output  11 each  latched offsets.
REQ-016 pixel_color  output  1  latched colour of the active job.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 timeout_err  output  1  sticky abort flag.

Function
REQ-019 The FSM SHALL have states IDLE, CLEAR, SETTLE, RUN, FINISH.
- IDLE: if any req bit is high, grant one requester, latch its str/x/y/color into the eng_* outputs and pixel_color, and go to CLEAR.
REQ-020 Arbitration SHALL be round-robin: search starts at index (last_served+1) mod NREQ; last_served resets to NREQ-1, so requester 0 wins first.
REQ-021 CLEAR SHALL assert eng_reset for exactly 2 cycles, then go to SETTLE.
REQ-022 SETTLE SHALL hold eng_reset and eng_start low for exactly 4 cycles, then go to RUN.
REQ-023 RUN SHALL hold eng_start high until eng_done is sampled high, then go to FINISH.
REQ-024 FINISH SHALL last 1 cycle, pulse req_done[granted], deassert eng_start, update last_served, and return to IDLE.
REQ-025 Minimum request-to-req_done latency SHALL be 9 cycles: 1 IDLE + 2 CLEAR + 4 SETTLE + 1 RUN with eng_done already high + 1 FINISH, req_done high in the FINISH cycle.
REQ-026 The eng_* outputs and pixel_color SHALL stay stable from the grant until leaving FINISH; requester inputs changing mid-job SHALL have no effect.
REQ-027 A 16-bit RUN cycle counter SHALL abort the job when it reaches TIMEOUT:
- set timeout_err;
- go to FINISH without pulsing req_done;
- advance last_served.
REQ-028 A requester whose req drops mid-job SHALL still have its job completed; req_done SHALL still pulse.
REQ-029 After FINISH, a requester still holding req (whether the job completed or aborted) SHALL be re-arbitrated as a new job. Round-robin gives it lowest priority next.
REQ-030 eng_done high outside RUN SHALL be ignored.
REQ-031 busy SHALL be combinational from state; all other outputs SHALL be registered.

Reset
REQ-032 While reset is high, the block SHALL:
- enter IDLE;
- drive eng_reset=0, eng_start=0, req_done=0, pixel_color=0, timeout_err=0;
- set eng_str, eng_x_off, eng_y_off to 0;
- set last_served=NREQ-1;
- clear all counters.
REQ-033 Reset asserted mid-job SHALL abort the job with no req_done pulse. The first grant after release SHALL occur at the earliest on the second cycle after reset falls.

Verification
REQ-034 Single request: req=001, str "WELCOME", x=220, y=10, color=1, eng_done tied high. Required: eng_reset high for cycles 2-3, eng_start high from cycle 8, req_done[0] pulses at cycle 9, eng_x_off=220 throughout.
REQ-035 Contention: req=111 held, engine done 20 cycles after start. Required: service order 0,1,2,0; each req_done one cycle wide; no overlap of eng_start between jobs.
REQ-036 Erase job: req=010, color=0, x=150, y=60. Required: pixel_color=0 for the whole job, and pixel_color stays 0 after return to IDLE until the next grant.
REQ-037 Timeout: TIMEOUT=100, eng_done never rises. Required: after 100 RUN cycles, FINISH is entered, timeout_err=1, no req_done, then IDLE.
REQ-038 Mid-job reset: reset pulsed for 1 cycle during SETTLE. Required: all outputs return to their reset values, no req_done, and a held req is re-granted after release.
REQ-039 Input churn: change req_str[0] and req_x[0] every cycle during RUN. Required: eng_str and eng_x_off hold the values latched at grant.
